seq_bin2bcd: RTL and testbench

SEQ_BIN2BCD -- requirements
Module: seq_bin2bcd

---
 rtl/seq_bin2bcd_pkg.sv | 21 ++
 rtl/seq_bin2bcd_dabble.sv | 10 +
 rtl/seq_bin2bcd.sv | 145 ++++++++++++++
 tb/tb_seq_bin2bcd.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_bin2bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
// Holds the default widths, the FSM state type and the bit-counter width helper.
package seq_bin2bcd_pkg;

   localparam int BIN_W_DEF  = 14;
   localparam int DIGITS_DEF = 5;

   // Counter must hold the value BIN_W itself, not just BIN_W-1.
   function automatic int cnt_width(input int bin_w);
      return $clog2(bin_w + 1);
   endfunction

   localparam int CNT_W_DEF = cnt_width(BIN_W_DEF);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/seq_bin2bcd_dabble.sv
// Per-digit double-dabble adjust: a BCD digit of 5 or more gets +3 before the
// next left shift so the carry lands in the next digit.
module dabble_digit (
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential shift-and-add-3 binary-to-BCD converter with registered sign and
// optional leading-zero blank mask (enabled by macro LEADING_ZERO_BLANK_EN).
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for start; outputs hold the last result
//   ST_SHIFT | one adjust+shift per cycle, BIN_W cycles
//   ST_DONE  | scratch holds the result; load outputs and pulse done
module seq_bin2bcd
   import seq_bin2bcd_pkg::*;
#(
   parameter int BIN_W  = BIN_W_DEF,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   input  logic                  sign_in,
   output logic                  busy,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd_out,
   output logic                  sign_out,
   output logic [DIGITS-1:0]     blank_out
);

   localparam int CNT_W = cnt_width(BIN_W);
   localparam int SCR_W = DIGITS * 4;
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BIN_W);
   localparam logic [DIGITS-1:0] DIG0_MASK = DIGITS'(1);

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIG0_MASK;
`else
   localparam logic [DIGITS-1:0] BLANK_RST = '0;
`endif

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic [SCR_W-1:0]    scr_q, scr_d;
   logic                sign_q, sign_d;
   logic [SCR_W-1:0]    bcd_q, bcd_d;
   logic                sign_out_q, sign_out_d;
   logic [DIGITS-1:0]   blank_q, blank_d;
   logic                done_q, done_d;

   logic [SCR_W-1:0]    scr_adj;
   logic [DIGITS-1:0]   blank_calc;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
      dabble_digit u_dabble (
         .digit_i (scr_q[g*4 +: 4]),
         .digit_o (scr_adj[g*4 +: 4])
      );
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit is blanked only if it and every digit above it are zero.
   logic higher_zero;
   always_comb begin
      blank_calc  = '0;
      higher_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         higher_zero   = higher_zero & (scr_q[i*4 +: 4] == 4'd0);
         blank_calc[i] = higher_zero;
      end
   end
`else
   assign blank_calc = '0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bin_d      = bin_q;
      scr_d      = scr_q;
      sign_d     = sign_q;
      bcd_d      = bcd_q;
      sign_out_d = sign_out_q;
      blank_d    = blank_q;
      done_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               bin_d   = bin_in;
               sign_d  = sign_in;
               scr_d   = '0;
               cnt_d   = CNT_LOAD;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            {scr_d, bin_d} = {scr_adj, bin_q} << 1;
            cnt_d          = cnt_q - 1'b1;
            if (cnt_d == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            bcd_d      = scr_q;
            // A zero magnitude is never reported as negative.
            sign_out_d = sign_q & (|scr_q);
            blank_d    = blank_calc;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bin_q      <= '0;
         scr_q      <= '0;
         sign_q     <= 1'b0;
         bcd_q      <= '0;
         sign_out_q <= 1'b0;
         blank_q    <= BLANK_RST;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bin_q      <= bin_d;
         scr_q      <= scr_d;
         sign_q     <= sign_d;
         bcd_q      <= bcd_d;
         sign_out_q <= sign_out_d;
         blank_q    <= blank_d;
         done_q     <= done_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign bcd_out   = bcd_q;
   assign sign_out  = sign_out_q;
   assign blank_out = blank_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Scoreboard bench for seq_bin2bcd: a driver pushes decimal-arithmetic
// expectations, an independent monitor checks every done pulse against them.
module tb_seq_bin2bcd;

   localparam int BIN_W   = 14;
   localparam int DIGITS  = 5;
   localparam int LATENCY = BIN_W + 1;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [DIGITS-1:0] BLANK_RST = 5'b11110;
`else
   localparam logic [DIGITS-1:0] BLANK_RST = 5'b00000;
`endif

   logic                sys_clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic [BIN_W-1:0]    bin_in = '0;
   logic                sign_in = 1'b0;
   logic                busy;
   logic                done;
   logic [DIGITS*4-1:0] bcd_out;
   logic                sign_out;
   logic [DIGITS-1:0]   blank_out;

   seq_bin2bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .start     (start),
      .bin_in    (bin_in),
      .sign_in   (sign_in),
      .busy      (busy),
      .done      (done),
      .bcd_out   (bcd_out),
      .sign_out  (sign_out),
      .blank_out (blank_out)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [DIGITS*4-1:0] bcd;
      logic                sign;
      logic [DIGITS-1:0]   blank;
      int                  start_cyc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic prev_done = 1'b0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   function automatic exp_t model(input int v, input bit s);
      exp_t e;
      int   p;
      e.bcd   = '0;
      e.blank = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         e.bcd[i*4 +: 4] = 4'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
         if (i > 0 && v < p) e.blank[i] = 1'b1;
`endif
         p = p * 10;
      end
      e.sign      = s && (v != 0);
      e.start_cyc = 0;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge sys_clk) begin
      if (prev_done) check("done_width", 32'(done), 32'd0);
      if (!rst && done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("bcd_out",   32'(bcd_out),   32'(e.bcd));
            check("sign_out",  32'(sign_out),  32'(e.sign));
            check("blank_out", 32'(blank_out), 32'(e.blank));
            check("latency",   32'(cyc - e.start_cyc), 32'(LATENCY));
            check("busy_at_done", 32'(busy), 32'd0);
         end
      end
      prev_done = done;
   end

   // Issue one conversion. scramble: wiggle inputs/start while busy.
   // second_at: inject a start with bin_in=99 at that cycle of the conversion.
   task automatic convert(input int v, input bit s, input bit scramble, input int second_at);
      exp_t e;
      bit   got;
      int   busy_cycles;
      @(negedge sys_clk);
      bin_in  = BIN_W'(v);
      sign_in = s;
      start   = 1'b1;
      e = model(v, s);
      @(posedge sys_clk);
      #1;
      e.start_cyc = cyc;
      sb.push_back(e);
      start = 1'b0;
      got = 1'b0;
      busy_cycles = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge sys_clk);
         if (done) begin
            got = 1'b1;
            start = 1'b0;
            break;
         end
         if (busy) busy_cycles++;
         start = 1'b0;
         if (scramble) begin
            bin_in  = BIN_W'($urandom);
            sign_in = 1'($urandom);
            start   = 1'($urandom);
         end
         if (n == second_at) begin
            bin_in = BIN_W'(99);
            start  = 1'b1;
         end
      end
      start = 1'b0;
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL done_timeout actual=no_done expected=done value=%0d", v);
      end
      check("busy_cycles", 32'(busy_cycles), 32'(LATENCY - 1 + 1));
      repeat (3) @(negedge sys_clk);
      check("hold_bcd",  32'(bcd_out),  32'(e.bcd));
      check("hold_sign", 32'(sign_out), 32'(e.sign));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"},  32'(busy),      32'd0);
      check({tag, "_done"},  32'(done),      32'd0);
      check({tag, "_bcd"},   32'(bcd_out),   32'd0);
      check({tag, "_sign"},  32'(sign_out),  32'd0);
      check({tag, "_blank"}, 32'(blank_out), 32'(BLANK_RST));
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      check_reset_state("reset");
      rst = 1'b0;

      convert(15, 1'b0, 1'b0, -1);
      convert(0, 1'b1, 1'b0, -1);
      convert(42, 1'b1, 1'b0, -1);
      convert(16383, 1'b0, 1'b0, -1);
      convert(48, 1'b0, 1'b0, 5);

      // Abort mid-conversion: no done may follow, outputs return to reset values.
      @(negedge sys_clk);
      bin_in  = BIN_W'(777);
      sign_in = 1'b1;
      start   = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      repeat (6) @(negedge sys_clk);
      rst   = 1'b1;
      start = 1'b1;
      @(negedge sys_clk);
      check_reset_state("abort");
      rst   = 1'b0;
      start = 1'b0;
      @(negedge sys_clk);
      check("abort_start_ignored", 32'(busy), 32'd0);
      repeat (20) @(negedge sys_clk);

      convert(123, 1'b1, 1'b0, -1);
      convert(9, 1'b1, 1'b1, -1);
      convert(10000, 1'b0, 1'b1, -1);

      for (int k = 0; k < 30; k++) begin
         convert(int'($urandom_range(0, 16383)), 1'($urandom), 1'b1, -1);
      end

      repeat (5) @(negedge sys_clk);
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
